lfsr_gen: RTL

Parametrised linear-feedback shift register generator for pseudo-random sequences in the lab designs, such as random delays and test patterns. Width is set by parameter, and the polynomial comes from a built-in table of maximal-length polynomials or a parameter override. Fibonacci or Galois form is selectable at run time, and a seed can be loaded. The block detects wrap-around, meaning a return to the start state, and can optionally measure the sequence period.

---
 rtl/lfsr_gen_if.sv | 29 ++
 rtl/lfsr_gen.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and status bundle for the lfsr_gen generator.
// There is no valid/ready handshake on this bundle. en/load/seed/mode are
// sampled on every rising clk edge. period is meaningful only while
// period_vld is high.
interface lfsr_gen_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             mode;
    logic [WIDTH-1:0] dout;
    logic             bit_out;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             period_vld;

    // Controller side: drives the commands and observes the generator.
    modport master (
        output en, load, seed, mode,
        input  dout, bit_out, wrap, period, period_vld
    );

    // Generator side.
    modport slave (
        input  en, load, seed, mode,
        output dout, bit_out, wrap, period, period_vld
    );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR with run-time Fibonacci/Galois selection, seed
// load, wrap-around detection against a start register, and an optional
// period measurement built only when LFSR_GEN_PERIOD_EN is defined.
module lfsr_gen #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input logic        clk,
    input logic        rst,
    lfsr_gen_if.slave  bus
);

    // Built-in maximal-length masks: bit k means term x^k, x^WIDTH implied.
    function automatic logic [WIDTH-1:0] table_mask();
        logic [15:0] m;
        case (WIDTH)
            2:       m = 16'h0003;
            3:       m = 16'h0005;
            4:       m = 16'h0009;
            5:       m = 16'h0009;
            6:       m = 16'h0021;
            7:       m = 16'h0041;
            8:       m = 16'h0071;
            9:       m = 16'h0021;
            10:      m = 16'h0081;
            11:      m = 16'h0201;
            12:      m = 16'h0C11;
            13:      m = 16'h1901;
            14:      m = 16'h3005;
            15:      m = 16'h4001;
            16:      m = 16'hA011;
            default: m = 16'h0003;
        endcase
        return WIDTH'(m);
    endfunction

    // The constant term is always part of the polynomial, even for overrides.
    localparam logic [WIDTH-1:0] MASK =
        ((TAPS != '0) ? TAPS : table_mask()) | WIDTH'(1);

    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] start_q;
    logic             mode_q;
    logic             wrap_q;

    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] seed_fix;
    logic             mode_chg;
    logic             wrap_now;

    // Next-state candidates. A step always uses the live mode input, so a step
    // taken in the same cycle as a mode change already uses the new form.
    always_comb begin
        fib_fb    = ^(s_q & {1'b1, MASK[WIDTH-1:1]});
        fib_next  = {s_q[WIDTH-2:0], fib_fb};
        gal_next  = {s_q[WIDTH-2:0], 1'b0} ^ (s_q[WIDTH-1] ? MASK : '0);
        step_next = bus.mode ? gal_next : fib_next;
        seed_fix  = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
        mode_chg  = (bus.mode != mode_q);
        // A mode change moves the reference to the current state, and a step
        // never lands on the current state again, so no wrap is possible then.
        wrap_now  = bus.en && !bus.load && !mode_chg && (step_next == start_q);
    end

    // State, start reference, mode history and the registered wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= WIDTH'(1);
            start_q <= WIDTH'(1);
            mode_q  <= bus.mode;
            wrap_q  <= 1'b0;
        end else begin
            mode_q <= bus.mode;
            wrap_q <= wrap_now;
            if (bus.load) begin
                s_q     <= seed_fix;
                start_q <= seed_fix;
            end else begin
                if (mode_chg) begin
                    start_q <= s_q;
                end
                if (bus.en) begin
                    s_q <= step_next;
                end
            end
        end
    end

    assign bus.dout    = s_q;
    assign bus.bit_out = s_q[WIDTH-1];
    assign bus.wrap    = wrap_q;

`ifdef LFSR_GEN_PERIOD_EN
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             period_vld_q;

    // Saturating step counter; its value plus one becomes the period on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else if (bus.load || mode_chg) begin
            // A step taken alongside a mode change is the first of the new run.
            count_q      <= (!bus.load && bus.en) ? WIDTH'(1) : '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else if (bus.en) begin
            if (wrap_now) begin
                period_q     <= (count_q == '1) ? '1 : count_q + WIDTH'(1);
                period_vld_q <= 1'b1;
                count_q      <= '0;
            end else if (count_q != '1) begin
                count_q <= count_q + WIDTH'(1);
            end
        end
    end

    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;
`else
    assign bus.period     = '0;
    assign bus.period_vld = 1'b0;
`endif

endmodule
